// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with valid/ready handshake,
// flush (bubble insertion) and an optional 2-entry skid buffer.
//
// Ports:
//   clk_i    rising-edge clock
//   start_i  asynchronous active-low reset
//   valid_i  upstream entry valid
//   ready_o  stage can accept (registered when SKID=1)
//   data_i   upstream payload
//   ctrl_i   upstream control bundle
//   flush_i  synchronous kill of held entries and this cycle's input
//   valid_o  downstream entry valid
//   ready_i  downstream accepts
//   data_o   head-entry payload
//   ctrl_o   head-entry control, zero whenever valid_o=0
//   count_o  entries held (0..2)
module pipe_stage_skid #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 12,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [1:0]        count_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL1 = 2'd1,
        S_FULL2 = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_count;
    logic [1:0]        w_count_nxt;

    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic              w_valid;
    logic              w_ready;
    logic              w_acc;
    logic              w_deq;
    logic              w_ld_main_in;
    logic              w_ld_main_skid;
    logic              w_ld_skid;

    assign w_valid = (r_state != S_EMPTY);

    // With a skid entry the ready depends only on state, so it
    // never has a combinational path from ready_i.
    generate
        if (SKID != 0) begin : g_skid
            assign w_ready = (r_state != S_FULL2);
        end else begin : g_noskid
            assign w_ready = ~w_valid | ready_i;
        end
    endgenerate

    assign w_acc = valid_i & w_ready;
    assign w_deq = w_valid & ready_i;

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush_i) begin
            w_state_nxt = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        w_ld_main_in = 1'b1;
                        w_state_nxt  = S_FULL1;
                    end
                end
                S_FULL1: begin
                    if (w_acc && w_deq) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_acc) begin
                        // unreachable without a skid entry:
                        // acc in FULL1 implies ready_i there
                        if (SKID != 0) begin
                            w_ld_skid   = 1'b1;
                            w_state_nxt = S_FULL2;
                        end
                    end else if (w_deq) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL2: begin
                    if (w_deq) begin
                        w_ld_main_skid = 1'b1;
                        w_state_nxt    = S_FULL1;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        w_count_nxt = 2'd0;
        unique case (w_state_nxt)
            S_FULL1: w_count_nxt = 2'd1;
            S_FULL2: w_count_nxt = 2'd2;
            default: w_count_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_state <= S_EMPTY;
            r_count <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush_i) begin
            if (CLEAR_DATA != 0) begin
                r_main_data <= '0;
                r_main_ctrl <= '0;
                r_skid_data <= '0;
                r_skid_ctrl <= '0;
            end
        end else begin
            if (w_ld_main_in) begin
                r_main_data <= data_i;
                r_main_ctrl <= ctrl_i;
            end else if (w_ld_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_ld_skid) begin
                r_skid_data <= data_i;
                r_skid_ctrl <= ctrl_i;
            end
        end
    end

    assign ready_o = w_ready;
    assign valid_o = w_valid;
    assign data_o  = r_main_data;
    // bubble: an unqualified consumer sees a NOP
    assign ctrl_o  = w_valid ? r_main_ctrl : '0;
    assign count_o = r_count;

endmodule
